shift_round_sequencer: RTL and testbench
========================================

Name: shift_round_sequencer

Overview:
- Sequences the 33-lane × 32-bit circular shifter through the rounds of a matrix-multiply pass.
- Each round: the shifter is moved by the configured step and direction, or bypassed via direct connection; then the MAC array is kicked and the sequencer waits for it to finish.
- Sits between the top-level control FSM (start/done) and the shifter plus MAC array.
- Owns every shifter control input: shift_enable, shift_direction, step_size, direct_connection.

Parameters:
- LANES, 33, number of 32-bit lanes in the shifter; step values are reduced modulo LANES.
- STEP_W, 6, width of step_size.
- ROUND_W, 6, width of the round counter and cfg_rounds.
- TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a pass; ignored unless idle.
- abort  in  1  level; forces return to IDLE.
- cfg_rounds  in  ROUND_W  number of rounds in the pass.
- cfg_step  in  STEP_W  shift step per round.
- cfg_dir  in  1  shift direction: 0 = right, 1 = down.
- cfg_bypass_first  in  1  round 0 uses direct connection, no shift.
- shift_enable  out  1  to shifter.
- shift_direction  out  1  to shifter.
- step_size  out  STEP_W  to shifter.
- direct_connection  out  1  to shifter.
- shift_ready  in  1  shifter completion.
- compute_start  out  1  one-cycle pulse to the MAC array.
- compute_done  in  1  MAC array completion.
- round_idx  out  ROUND_W  current round number.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at the end of a pass.
- error  out  1  sticky watchdog error.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State = IDLE.
  - All outputs 0; round_idx = 0.
- IDLE:
  - start=1 latches cfg_* into internal registers → LOAD.
  - Config inputs are not sampled again until the next start.
- LOAD (1 cycle):
  - step_eff = cfg_step ≥ LANES ? cfg_step − LANES : cfg_step. Valid because the 6-bit maximum of 63 is below 2·LANES.
  - shift_direction and step_size are driven from the latched values and stay stable for the whole pass.
  - rounds = 0 → DONE.
  - Otherwise, if bypass_first: direct_connection = 1 → COMPUTE.
  - Otherwise → SHIFT.
- SHIFT:
  - shift_enable = 1 from the entry cycle until the cycle in which shift_ready is sampled high.
  - Exit → COMPUTE, with shift_enable low in the next cycle.
  - step_eff = 0 still performs the handshake.
- COMPUTE:
  - compute_start pulses for exactly one cycle, the entry cycle.
  - compute_done is sampled from the following cycle onward; compute_done in the entry cycle is ignored.
  - On compute_done → NEXT.
- NEXT (1 cycle):
  - direct_connection = 0.
  - If round_idx == rounds − 1 → DONE; otherwise round_idx += 1 → SHIFT.
- DONE (1 cycle):
  - done = 1.
  - round_idx is cleared to 0 → IDLE.
- shift_ready and compute_done are ignored outside SHIFT and COMPUTE respectively.
- abort (highest priority, any non-IDLE state):
  - Next state IDLE.
  - shift_enable, direct_connection and compute_start go low the next cycle; round_idx = 0.
  - No done pulse.
  - error is cleared.
- start together with abort: abort wins.
- start while busy is ignored; there is no queueing.
- busy = (state != IDLE).
  - busy falls in the cycle after the done pulse.
  - Back-to-back passes are therefore separated by at least one IDLE cycle.

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in SHIFT and COMPUTE and resets on every state entry.
  - When it reaches TIMEOUT: go to ERR state, drive shift_enable = 0, set error = 1 (sticky).
  - ERR leaves only on abort, or on start (which clears error and proceeds to LOAD); no done pulse.
- Not defined:
  - No counter and no ERR state; handshakes wait indefinitely.
  - error tied to 0.

Decomposition:
- Package shift_seq_pkg:
  - State encoding: IDLE, LOAD, SHIFT, COMPUTE, NEXT, DONE, ERR.
  - Constants LANES, STEP_W, ROUND_W, TIMEOUT.
- Sub-module seq_watchdog:
  - Counter with clear, enable and expired outputs.
  - Instantiated only under SEQ_WATCHDOG_EN.

Test Plan:
- cfg_rounds=3, cfg_step=2, cfg_dir=1, no bypass; shift_ready one cycle after enable; compute_done 4 cycles after start → three shift/compute pairs, round_idx 0→1→2, step_size=2, shift_direction=1, one done pulse, busy then low.
- cfg_bypass_first=1, cfg_rounds=2 → round 0: direct_connection=1 with no shift_enable; round 1: direct_connection=0 and shift_enable asserted.
- cfg_step=35 → step_size=2; cfg_step=33 → step_size=0 and the handshake still completes.
- cfg_rounds=0 → done pulse 2 cycles after start, no shift_enable or compute_start.
- abort asserted in the middle of SHIFT with shift_ready held low → IDLE next cycle, shift_enable=0, no done; start issued while busy is ignored.
- SEQ_WATCHDOG_EN with shift_ready stuck low → error=1 after 64 cycles in SHIFT; a subsequent start clears error and runs a full pass.

Source files
------------

// File: rtl/shift_round_sequencer_pkg.sv
// Shared constants, state encoding and step reduction for the shift/round sequencer.
// SEQ_WATCHDOG_EN enables the SHIFT/COMPUTE watchdog and the ERR state.
package shift_seq_pkg;

    localparam int LANES   = 33;
    localparam int STEP_W  = 6;
    localparam int ROUND_W = 6;
    localparam int TIMEOUT = 64;
    localparam int WD_W    = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        COMPUTE,
        NEXT,
        DONE,
        ERR
    } state_t;

    // One subtraction is enough: the largest step (63) is below 2*LANES.
    function automatic logic [STEP_W-1:0] reduce_step(
        input logic [STEP_W-1:0] s
    );
        return (s >= STEP_W'(LANES)) ? s - STEP_W'(LANES) : s;
    endfunction

endpackage

// File: rtl/shift_round_sequencer_if.sv
// Control bundle between the sequencer (master) and the shifter plus MAC array (slave).
// Signal names match the shifter/MAC pins one-to-one.
interface shift_seq_if;
    import shift_seq_pkg::*;

    logic              shift_enable;
    logic              shift_direction;
    logic [STEP_W-1:0] step_size;
    logic              direct_connection;
    logic              shift_ready;
    logic              compute_start;
    logic              compute_done;

    modport master (
        output shift_enable,
        output shift_direction,
        output step_size,
        output direct_connection,
        output compute_start,
        input  shift_ready,
        input  compute_done
    );

    modport slave (
        input  shift_enable,
        input  shift_direction,
        input  step_size,
        input  direct_connection,
        input  compute_start,
        output shift_ready,
        output compute_done
    );

endinterface

// File: rtl/shift_round_sequencer_watchdog.sv
// Cycle watchdog for the handshake states; clr marks the first cycle in a state.
// Only instantiated when SEQ_WATCHDOG_EN is defined.
module seq_watchdog
    import shift_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [WD_W-1:0] cnt;
    logic [WD_W-1:0] cur;

    // cur is the number of cycles already spent in the state before this one
    assign cur     = clr ? '0 : cnt;
    assign expired = en && (cur == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cur + WD_W'(1);
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/shift_round_sequencer.sv
// Steps the circular shifter and MAC array through the rounds of one pass.
// Define SEQ_WATCHDOG_EN to add the handshake watchdog and sticky error.
module shift_round_sequencer
    import shift_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [ROUND_W-1:0] cfg_rounds,
    input  logic [STEP_W-1:0]  cfg_step,
    input  logic               cfg_dir,
    input  logic               cfg_bypass_first,
    shift_seq_if.master        sh,
    output logic [ROUND_W-1:0] round_idx,
    output logic               busy,
    output logic               done,
    output logic               error
);

    state_t             state;
    logic [ROUND_W-1:0] rounds;
    logic [STEP_W-1:0]  step_q;
    logic               dir_q;
    logic               bypass;

`ifdef SEQ_WATCHDOG_EN
    state_t prev_state;
    logic   err_q;
    logic   wd_en;
    logic   wd_clr;
    logic   wd_expired;

    assign wd_en  = (state == SHIFT) || (state == COMPUTE);
    assign wd_clr = (state != prev_state);
    assign error  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_state <= IDLE;
        else        prev_state <= state;
    end

    seq_watchdog u_wd (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            rounds               <= '0;
            step_q               <= '0;
            dir_q                <= 1'b0;
            bypass               <= 1'b0;
            round_idx            <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            sh.shift_enable      <= 1'b0;
            sh.shift_direction   <= 1'b0;
            sh.step_size         <= '0;
            sh.direct_connection <= 1'b0;
            sh.compute_start     <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            err_q                <= 1'b0;
`endif
        end else if (abort) begin
            state                <= IDLE;
            round_idx            <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            sh.shift_enable      <= 1'b0;
            sh.direct_connection <= 1'b0;
            sh.compute_start     <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            err_q                <= 1'b0;
`endif
        end else begin
            done             <= 1'b0;
            sh.compute_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rounds <= cfg_rounds;
                        step_q <= cfg_step;
                        dir_q  <= cfg_dir;
                        bypass <= cfg_bypass_first;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    sh.shift_direction <= dir_q;
                    sh.step_size       <= reduce_step(step_q);
                    if (rounds == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (bypass) begin
                        sh.direct_connection <= 1'b1;
                        sh.compute_start     <= 1'b1;
                        state                <= COMPUTE;
                    end else begin
                        sh.shift_enable <= 1'b1;
                        state           <= SHIFT;
                    end
                end
                SHIFT: begin
`ifdef SEQ_WATCHDOG_EN
                    if (wd_expired) begin
                        sh.shift_enable <= 1'b0;
                        err_q           <= 1'b1;
                        state           <= ERR;
                    end else
`endif
                    if (sh.shift_ready) begin
                        sh.shift_enable  <= 1'b0;
                        sh.compute_start <= 1'b1;
                        state            <= COMPUTE;
                    end
                end
                COMPUTE: begin
`ifdef SEQ_WATCHDOG_EN
                    if (wd_expired) begin
                        sh.direct_connection <= 1'b0;
                        err_q                <= 1'b1;
                        state                <= ERR;
                    end else
`endif
                    // a done seen in the kick cycle belongs to no request of ours
                    if (!sh.compute_start && sh.compute_done) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    sh.direct_connection <= 1'b0;
                    if (round_idx == rounds - ROUND_W'(1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        round_idx       <= round_idx + ROUND_W'(1);
                        sh.shift_enable <= 1'b1;
                        state           <= SHIFT;
                    end
                end
                DONE: begin
                    round_idx <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
`ifdef SEQ_WATCHDOG_EN
                ERR: begin
                    if (start) begin
                        rounds    <= cfg_rounds;
                        step_q    <= cfg_step;
                        dir_q     <= cfg_dir;
                        bypass    <= cfg_bypass_first;
                        round_idx <= '0;
                        err_q     <= 1'b0;
                        state     <= LOAD;
                    end
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_round_sequencer.sv
// Scoreboard bench: directed passes push expected shift/compute/done events,
// a negedge monitor pops and compares them as the sequencer emits them.
module tb_shift_round_sequencer;
    import shift_seq_pkg::*;

    localparam logic [1:0] K_SH = 2'd0;
    localparam logic [1:0] K_CS = 2'd1;
    localparam logic [1:0] K_DN = 2'd2;

    typedef struct packed {
        logic [1:0]         kind;
        logic [ROUND_W-1:0] rnd;
        logic [STEP_W-1:0]  step;
        logic               dir;
        logic               dc;
    } ev_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [ROUND_W-1:0] cfg_rounds = '0;
    logic [STEP_W-1:0]  cfg_step = '0;
    logic               cfg_dir = 1'b0;
    logic               cfg_bypass_first = 1'b0;
    logic [ROUND_W-1:0] round_idx;
    logic               busy;
    logic               done;
    logic               error;

    shift_seq_if sif ();

    shift_round_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .cfg_rounds       (cfg_rounds),
        .cfg_step         (cfg_step),
        .cfg_dir          (cfg_dir),
        .cfg_bypass_first (cfg_bypass_first),
        .sh               (sif),
        .round_idx        (round_idx),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    ev_t exp_q[$];
    int  n_chk = 0;
    int  n_pass = 0;
    bit  stuck = 1'b0;
    bit  early = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, expv);
    endtask

    task automatic push(input logic [1:0] k, input int r, input int s,
                        input bit d, input bit dc);
        ev_t e;
        e.kind = k;
        e.rnd  = ROUND_W'(r);
        e.step = STEP_W'(s);
        e.dir  = d;
        e.dc   = dc;
        exp_q.push_back(e);
    endtask

    function automatic ev_t mk(input logic [1:0] k);
        ev_t e;
        e.kind = k;
        e.rnd  = round_idx;
        e.step = sif.step_size;
        e.dir  = sif.shift_direction;
        e.dc   = sif.direct_connection;
        return e;
    endfunction

    task automatic obs(input ev_t got);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            $display("FAIL event: got unexpected %h want none", got);
        end else begin
            e = exp_q.pop_front();
            if (got == e) n_pass++;
            else $display("FAIL event: got %h want %h", got, e);
        end
    endtask

    // monitor
    initial begin
        logic prev_se;
        prev_se = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (sif.shift_enable && !prev_se) obs(mk(K_SH));
                if (sif.compute_start) obs(mk(K_CS));
                if (done) obs(mk(K_DN));
            end
            prev_se = sif.shift_enable;
        end
    end

    // shifter and MAC responders
    initial begin
        int sc;
        int cc;
        sc = 0;
        cc = 0;
        sif.shift_ready  = 1'b0;
        sif.compute_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sif.shift_enable) sc++;
            else sc = 0;
            sif.shift_ready = !stuck && (sc >= 2);
            if (sif.compute_start) cc = 1;
            else if (cc > 0) cc++;
            sif.compute_done = (cc == 5) || (early && sif.compute_start);
            if (cc == 5) cc = 0;
        end
    end

    task automatic pulse_start(input int r, input int s, input bit d, input bit b);
        @(posedge clk);
        #1;
        cfg_rounds       = ROUND_W'(r);
        cfg_step         = STEP_W'(s);
        cfg_dir          = d;
        cfg_bypass_first = b;
        start            = 1'b1;
        @(posedge clk);
        #1;
        start            = 1'b0;
        cfg_rounds       = ROUND_W'($urandom);
        cfg_step         = STEP_W'($urandom);
        cfg_dir          = ~d;
        cfg_bypass_first = ~b;
    endtask

    // lat counts cycles from the start cycle to the done cycle
    task automatic run_pass(input string nm, input int r, input int s,
                            input bit d, input bit b, input int want_lat);
        int lat;
        pulse_start(r, s, d, b);
        chk({nm, "_busy"}, int'(busy), 1);
        lat = 1;
        while (!done && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_lat"}, lat, want_lat);
        @(posedge clk);
        #1;
        chk({nm, "_busy_end"}, int'(busy), 0);
        chk({nm, "_round_end"}, int'(round_idx), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        #23;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_se", int'(sif.shift_enable), 0);
        chk("rst_cs", int'(sif.compute_start), 0);
        chk("rst_dc", int'(sif.direct_connection), 0);
        chk("rst_step", int'(sif.step_size), 0);
        chk("rst_dir", int'(sif.shift_direction), 0);
        chk("rst_round", int'(round_idx), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int r = 0; r < 3; r++) begin
            push(K_SH, r, 2, 1, 0);
            push(K_CS, r, 2, 1, 0);
        end
        push(K_DN, 2, 2, 1, 0);
        run_pass("three_rounds", 3, 2, 1, 0, 26);

        early = 1'b1;
        push(K_CS, 0, 5, 0, 1);
        push(K_SH, 1, 5, 0, 0);
        push(K_CS, 1, 5, 0, 0);
        push(K_DN, 1, 5, 0, 0);
        run_pass("bypass", 2, 5, 0, 1, 16);
        early = 1'b0;

        push(K_SH, 0, 2, 0, 0);
        push(K_CS, 0, 2, 0, 0);
        push(K_DN, 0, 2, 0, 0);
        run_pass("step35", 1, 35, 0, 0, 10);

        push(K_SH, 0, 0, 1, 0);
        push(K_CS, 0, 0, 1, 0);
        push(K_DN, 0, 0, 1, 0);
        run_pass("step33", 1, 33, 1, 0, 10);

        push(K_DN, 0, 30, 1, 0);
        run_pass("zero_rounds", 0, 63, 1, 0, 2);

        stuck = 1'b1;
        push(K_SH, 0, 4, 1, 0);
        pulse_start(3, 4, 1, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_se_held", int'(sif.shift_enable), 1);
        start    = 1'b1;
        cfg_step = 6'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_start_step", int'(sif.step_size), 4);
        chk("busy_start_busy", int'(busy), 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_se", int'(sif.shift_enable), 0);
        chk("abort_round", int'(round_idx), 0);
        chk("abort_done", int'(done), 0);
        stuck = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", int'(busy), 0);
        repeat (3) @(posedge clk);

`ifdef SEQ_WATCHDOG_EN
        begin
            int se_cycles;
            int n;
            stuck = 1'b1;
            push(K_SH, 0, 1, 0, 0);
            pulse_start(1, 1, 0, 0);
            se_cycles = 0;
            n = 0;
            while (!error && n < 200) begin
                if (sif.shift_enable) se_cycles++;
                @(posedge clk);
                #1;
                n++;
            end
            chk("wd_error", int'(error), 1);
            chk("wd_cycles", se_cycles, 64);
            chk("wd_se", int'(sif.shift_enable), 0);
            chk("wd_busy", int'(busy), 1);
            stuck = 1'b0;
            push(K_SH, 0, 1, 0, 0);
            push(K_CS, 0, 1, 0, 0);
            push(K_DN, 0, 1, 0, 0);
            run_pass("wd_restart", 1, 1, 0, 0, 10);
            chk("wd_error_clr", int'(error), 0);
        end
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
